// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: debounced push-button to single-cycle pulse with optional auto-repeat
module btn_pulse_gen #(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic pulse,
  output logic held
);
  typedef enum logic [2:0] {S_IDLE, S_DB_PRESS, S_PULSE, S_HELD, S_DB_REL} state_t;
  localparam logic [CNT_W-1:0] one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] db_max  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] rpt_max = CNT_W'(REPEAT_CYCLES - 1);
  state_t           state, state_n;
  logic [1:0]       sync;
  logic [CNT_W-1:0] db_cnt, db_n, rpt_cnt, rpt_n;
  logic             btn_s, db_done, rpt_done;
  assign btn_s    = sync[1] ^ ACTIVE_LOW;
  assign db_done  = db_cnt == db_max;
  assign rpt_done = rpt_cnt == rpt_max;
  assign pulse    = state == S_PULSE;
  assign held     = state inside {S_PULSE, S_HELD, S_DB_REL};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= {2{ACTIVE_LOW}};
      state   <= S_IDLE;
      db_cnt  <= '0;
      rpt_cnt <= '0;
    end else begin
      sync    <= {sync[0], btn_in};
      state   <= state_n;
      db_cnt  <= db_n;
      rpt_cnt <= rpt_n;
    end
  end
  always_comb begin
    state_n = state;
    db_n    = db_cnt;
    rpt_n   = rpt_cnt;
    case (state)
      S_IDLE: begin
        state_n = btn_s ? S_DB_PRESS : S_IDLE;
        db_n    = btn_s ? one : '0;
      end
      S_DB_PRESS: begin
        state_n = !btn_s ? S_IDLE : db_done ? S_PULSE : S_DB_PRESS;
        db_n    = (!btn_s || db_done) ? '0 : db_cnt + one;
      end
      S_PULSE: begin
        state_n = S_HELD;
        db_n    = '0;
        rpt_n   = '0;
      end
      S_HELD: begin
        state_n = !btn_s ? S_DB_REL : (repeat_en && rpt_done) ? S_PULSE : S_HELD;
        db_n    = !btn_s ? one : db_cnt;
        rpt_n   = (btn_s && repeat_en && !rpt_done) ? rpt_cnt + one : '0;
      end
      S_DB_REL: begin
        state_n = btn_s ? S_HELD : db_done ? S_IDLE : S_DB_REL;
        db_n    = (btn_s || db_done) ? '0 : db_cnt + one;
        rpt_n   = btn_s ? '0 : rpt_cnt;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule
